// File: rtl/temp_display_pkg.sv
// Shared constants for the temperature display path: digit count, BCD width,
// converter states and the 7-segment pattern table.
package temp_display_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int BCD_W      = 12;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    CONV_IDLE,
    CONV_RUN
  } conv_state_t;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}; codes 10..15 never occur.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bin_to_bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit per clock).
module bin_to_bcd8
  import temp_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       value_in,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_t      state;
  logic [7:0]       shreg;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_adj;
  logic [BCD_W-1:0] acc_shift;
  logic [2:0]       bit_cnt;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
    acc_shift = (acc_adj << 1) | {{(BCD_W-1){1'b0}}, shreg[7]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CONV_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      acc     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        CONV_IDLE: begin
          if (load) begin
            shreg   <= value_in;
            acc     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= CONV_RUN;
          end
        end
        CONV_RUN: begin
          acc     <= acc_shift;
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + 3'd1;
          // bcd_out only moves on the last shift, so partial digits never reach the display.
          if (bit_cnt == 3'd7) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            bcd   <= acc_shift;
            state <= CONV_IDLE;
          end
        end
        default: state <= CONV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/temp_display_driver.sv
// Converts an 8-bit value to BCD and drives a multiplexed 3-digit 7-segment display
// with leading-zero blanking and optional blink.
module temp_display_driver
  import temp_display_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_DIV      = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       value_in,
  input  logic             load,
  input  logic             blink_en,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out,
  output logic [6:0]       seg,
  output logic [2:0]       an
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [1:0]         idx;
  logic               phase;
  logic               phase_eff;
  logic [3:0]         hund, tens, ones, digit;
  logic               shown;
  logic [6:0]         seg_nxt;
  logic [2:0]         an_nxt;

  bin_to_bcd8 u_conv (
    .clk      (clk),
    .rst      (rst),
    .value_in (value_in),
    .load     (load),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == 2'(NUM_DIGITS - 1)) ? 2'd0 : idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !blink_en) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Dropping blink_en overrides the phase immediately so the scan reappears on the next edge.
  always_comb begin
    hund      = bcd_out[11:8];
    tens      = bcd_out[7:4];
    ones      = bcd_out[3:0];
    phase_eff = phase | ~blink_en;
    case (idx)
      2'd1:    begin digit = tens; shown = (hund != 4'd0) || (tens != 4'd0); end
      2'd2:    begin digit = hund; shown = (hund != 4'd0); end
      default: begin digit = ones; shown = 1'b1; end
    endcase
    seg_nxt = seg_decode(digit);
    an_nxt  = (shown && phase_eff) ? (3'b001 << idx) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= {7{SEG_ACTIVE_LOW}};
      an  <= {3{SEG_ACTIVE_LOW}};
    end else begin
      seg <= seg_nxt ^ {7{SEG_ACTIVE_LOW}};
      an  <= an_nxt ^ {3{SEG_ACTIVE_LOW}};
    end
  end

endmodule
